// File: rtl/credit_arb_pkg.sv
// Shared types and helpers for the credit pool arbiter: FSM state, pointer width,
// and the amount-slice extractor used on the packed request-amount bus.
package credit_arb_pkg;

   typedef enum logic [0:0] {
      ARB     = 1'b0,
      RESERVE = 1'b1
   } arb_state_e;

   localparam int MAX_REQ = 8;
   localparam int MAX_AMT = 16;
   // Pointer width covers the largest supported requester count.
   localparam int PTR_SZ  = $clog2(MAX_REQ);

   // Zero-extended slice [i*amt_sz +: amt_sz] of a packed amount bus.
   function automatic logic [MAX_AMT-1:0] amt_of(
      input logic [MAX_REQ*MAX_AMT-1:0] vec,
      input int unsigned                i,
      input int unsigned                amt_sz
   );
      return MAX_AMT'((vec >> (i * amt_sz)) & ~({(MAX_REQ*MAX_AMT){1'b1}} << amt_sz));
   endfunction

endpackage

// File: rtl/credit_pool_arbiter_rr_select.sv
// Round-robin picker: first set bit of mask at or after ptr (wrapping), as one-hot plus index.
module rr_select
   import credit_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]      mask_i,
   input  logic [PTR_SZ-1:0] ptr_i,
   output logic [N-1:0]      gnt_o,
   output logic [PTR_SZ-1:0] idx_o
);

   logic [N-1:0]   rot_mask;
   logic [N-1:0]   first_hot;
   logic [2*N-1:0] unrot;
   int             first_k;
   int             idx_sum;

   always_comb begin
      // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
      rot_mask  = N'({mask_i, mask_i} >> ptr_i);
      first_hot = '0;
      first_k   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot_mask[k]) begin
            first_hot    = '0;
            first_hot[k] = 1'b1;
            first_k      = k;
         end
      end
      unrot = {N'(0), first_hot} << ptr_i;
      gnt_o = unrot[N-1:0] | unrot[2*N-1:N];

      idx_sum = int'(ptr_i) + first_k;
      if (idx_sum >= N) begin
         idx_sum = idx_sum - N;
      end
      idx_o = PTR_SZ'(idx_sum);
   end

endmodule

// File: rtl/credit_pool_arbiter.sv
// Shared credit pool with round-robin grant, same-edge return, saturation at MAX_CREDITS,
// and a starvation guard that reserves the pool for a repeatedly denied pointer requester.
module credit_pool_arbiter
   import credit_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int CNT_SZ       = 10,
   parameter int AMT_SZ       = 6,
   parameter int INIT_CREDITS = 256,
   parameter int MAX_CREDITS  = 512,
   parameter int STARVE_LIM   = 8
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NUM_REQ-1:0]        req__ENA,
   input  logic [NUM_REQ*AMT_SZ-1:0] req__v,
   output logic [NUM_REQ-1:0]        req__RDY,
   input  logic                      ret__ENA,
   input  logic [CNT_SZ-1:0]         ret__v,
   output logic                      ret__RDY,
   output logic [CNT_SZ-1:0]         read,
   output logic                      positive,
   output logic                      reserve_active,
   output logic                      overflow_err
);

   localparam int SW = $clog2(STARVE_LIM + 1);

   logic [CNT_SZ-1:0]          cnt_q, cnt_d;
   logic [PTR_SZ-1:0]          ptr_q, ptr_d;
   logic [SW-1:0]              starve_q, starve_d;
   arb_state_e                 state_q, state_d;
   logic                       ovf_q, ovf_d;
   logic                       pos_q, pos_d;

   logic [MAX_REQ*MAX_AMT-1:0] amt_vec;
   logic [CNT_SZ-1:0]          amt [NUM_REQ];
   logic [NUM_REQ-1:0]         elig;
   logic [NUM_REQ-1:0]         ptr_onehot;
   logic [NUM_REQ-1:0]         sel_mask;
   logic [NUM_REQ-1:0]         gnt;
   logic [PTR_SZ-1:0]          gnt_idx;
   logic                       any_gnt;
   logic                       ptr_gnt;
   logic                       ptr_req;
   logic [CNT_SZ-1:0]          gnt_amt;
   logic [CNT_SZ:0]            sum;

   function automatic logic [PTR_SZ-1:0] wrap_inc(input logic [PTR_SZ-1:0] p);
      return (p == PTR_SZ'(NUM_REQ - 1)) ? '0 : p + 1'b1;
   endfunction

   assign amt_vec = (MAX_REQ*MAX_AMT)'(req__v);

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_amt
         assign amt[gi]  = CNT_SZ'(amt_of(amt_vec, gi, AMT_SZ));
         assign elig[gi] = req__ENA[gi] & (amt[gi] <= cnt_q);
      end
   endgenerate

   assign ptr_onehot = NUM_REQ'(1) << ptr_q;
   assign sel_mask   = (state_q == RESERVE) ? (elig & ptr_onehot) : elig;

   rr_select #(.N(NUM_REQ)) u_sel (
      .mask_i (sel_mask),
      .ptr_i  (ptr_q),
      .gnt_o  (gnt),
      .idx_o  (gnt_idx)
   );

   // A grant in a reset cycle is void, so the handshake is masked too.
   assign req__RDY = RST ? '0 : gnt;

   always_comb begin
      any_gnt = |req__RDY;
      ptr_gnt = |(req__RDY & ptr_onehot);
      ptr_req = |(req__ENA & ptr_onehot);
      gnt_amt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req__RDY[i]) begin
            gnt_amt = amt[i];
         end
      end

      ptr_d    = ptr_q;
      starve_d = starve_q;
      state_d  = state_q;
      if (ptr_gnt) begin
         ptr_d    = wrap_inc(ptr_q);
         starve_d = '0;
         state_d  = ARB;
      end else if (!ptr_req) begin
         starve_d = '0;
         state_d  = ARB;
         if (any_gnt) begin
            ptr_d = wrap_inc(gnt_idx);
         end
      end else begin
         if (starve_q != SW'(STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
         end
         if (starve_d == SW'(STARVE_LIM)) begin
            state_d = RESERVE;
         end
      end

      sum = {1'b0, cnt_q} + (ret__ENA ? {1'b0, ret__v} : '0) - {1'b0, gnt_amt};
      ovf_d = ovf_q;
      if (sum > (CNT_SZ+1)'(MAX_CREDITS)) begin
         cnt_d = CNT_SZ'(MAX_CREDITS);
         ovf_d = 1'b1;
      end else begin
         cnt_d = sum[CNT_SZ-1:0];
      end
      pos_d = (cnt_d != '0);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q    <= CNT_SZ'(INIT_CREDITS);
         ptr_q    <= '0;
         starve_q <= '0;
         state_q  <= ARB;
         ovf_q    <= 1'b0;
         pos_q    <= (INIT_CREDITS > 0);
      end else begin
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         starve_q <= starve_d;
         state_q  <= state_d;
         ovf_q    <= ovf_d;
         pos_q    <= pos_d;
      end
   end

   assign ret__RDY       = 1'b1;
   assign read           = cnt_q;
   assign positive       = pos_q;
   assign reserve_active = (state_q == RESERVE);
   assign overflow_err   = ovf_q;

endmodule

// File: tb/tb_credit_pool_arbiter.sv
// Directed vector bench for credit_pool_arbiter: table of per-cycle stimulus with
// hand-computed grant and post-edge pool/flag values, plus reset sequences.
module tb_credit_pool_arbiter;

   logic        CLK;
   logic        RST;
   logic [3:0]  req__ENA;
   logic [23:0] req__v;
   logic [3:0]  req__RDY;
   logic        ret__ENA;
   logic [9:0]  ret__v;
   logic        ret__RDY;
   logic [9:0]  read;
   logic        positive;
   logic        reserve_active;
   logic        overflow_err;

   credit_pool_arbiter dut (
      .CLK            (CLK),
      .RST            (RST),
      .req__ENA       (req__ENA),
      .req__v         (req__v),
      .req__RDY       (req__RDY),
      .ret__ENA       (ret__ENA),
      .ret__v         (ret__v),
      .ret__RDY       (ret__RDY),
      .read           (read),
      .positive       (positive),
      .reserve_active (reserve_active),
      .overflow_err   (overflow_err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic        rst;
      logic [3:0]  ena;
      logic [23:0] amts;
      logic        ret_en;
      logic [9:0]  ret_v;
      logic [3:0]  e_rdy;
      logic [9:0]  e_read;
      logic        e_pos;
      logic        e_rsv;
      logic        e_ovf;
   } vec_t;

   vec_t tbl [48];
   int   n_tbl  = 0;
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic add(input logic r, input logic [3:0] ena,
                      input int a0, input int a1, input int a2, input int a3,
                      input logic ren, input int rv,
                      input logic [3:0] e_rdy, input int e_read,
                      input logic e_pos, input logic e_rsv, input logic e_ovf);
      tbl[n_tbl].rst    = r;
      tbl[n_tbl].ena    = ena;
      tbl[n_tbl].amts   = {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
      tbl[n_tbl].ret_en = ren;
      tbl[n_tbl].ret_v  = 10'(rv);
      tbl[n_tbl].e_rdy  = e_rdy;
      tbl[n_tbl].e_read = 10'(e_read);
      tbl[n_tbl].e_pos  = e_pos;
      tbl[n_tbl].e_rsv  = e_rsv;
      tbl[n_tbl].e_ovf  = e_ovf;
      n_tbl++;
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s vec %0d: got %0d, expected %0d", nm, idx, act, exp);
      end
   endtask

   task automatic apply(input int k);
      @(negedge CLK);
      RST      = tbl[k].rst;
      req__ENA = tbl[k].ena;
      req__v   = tbl[k].amts;
      ret__ENA = tbl[k].ret_en;
      ret__v   = tbl[k].ret_v;
      #1;
      n_vec++;
      chk("req_rdy", k, 32'(req__RDY), 32'(tbl[k].e_rdy));
      @(posedge CLK);
      #1;
      chk("read", k, 32'(read), 32'(tbl[k].e_read));
      chk("positive", k, 32'(positive), 32'(tbl[k].e_pos));
      chk("reserve_active", k, 32'(reserve_active), 32'(tbl[k].e_rsv));
      chk("overflow_err", k, 32'(overflow_err), 32'(tbl[k].e_ovf));
      $display("vec %0d: rst=%0b ena=%b ret=%0b/%0d rdy=%b read=%0d pos=%0b rsv=%0b ovf=%0b",
               k, tbl[k].rst, tbl[k].ena, tbl[k].ret_en, tbl[k].ret_v,
               req__RDY, read, positive, reserve_active, overflow_err);
   endtask

   initial begin
      // rst ena     a0 a1 a2 a3 ren rv   | rdy     read pos rsv ovf
      add(0, 4'hF,    1, 1, 1, 1, 0, 0,    4'b0001, 255, 1, 0, 0);
      add(0, 4'hF,    1, 1, 1, 1, 0, 0,    4'b0010, 254, 1, 0, 0);
      add(0, 4'hF,    1, 1, 1, 1, 0, 0,    4'b0100, 253, 1, 0, 0);
      add(0, 4'hF,    1, 1, 1, 1, 0, 0,    4'b1000, 252, 1, 0, 0);
      add(0, 4'hF,    1, 1, 1, 1, 0, 0,    4'b0001, 251, 1, 0, 0);
      add(0, 4'hF,   60,60,60,60, 0, 0,    4'b0010, 191, 1, 0, 0);
      add(0, 4'hF,   60,60,60,60, 0, 0,    4'b0100, 131, 1, 0, 0);
      add(0, 4'hF,   60,60,60,60, 0, 0,    4'b1000,  71, 1, 0, 0);
      add(0, 4'hF,   60,60,60,60, 0, 0,    4'b0001,  11, 1, 0, 0);
      add(0, 4'b0010, 0, 1, 0, 0, 0, 0,    4'b0010,  10, 1, 0, 0);
      // return in the same cycle is not visible to that cycle's grant
      add(0, 4'b0100, 0, 0,12, 0, 1, 5,    4'b0000,  15, 1, 0, 0);
      add(0, 4'b0100, 0, 0,12, 0, 0, 0,    4'b0100,   3, 1, 0, 0);
      add(0, 4'b1000, 0, 0, 0, 3, 0, 0,    4'b1000,   0, 0, 0, 0);
      // zero amount at an empty pool; ptr=0 idle so ptr <= 3+1 wraps to 0
      add(0, 4'b1000, 0, 0, 0, 0, 1, 28,   4'b1000,  28, 1, 0, 0);
      for (int d = 1; d <= 8; d++)
         add(0, 4'b0011, 40, 1, 0, 0, 0, 0, 4'b0010, 28 - d, 1, (d == 8), 0);
      add(0, 4'b0011, 40, 1, 0, 0, 0, 0,   4'b0000,  20, 1, 1, 0);
      add(0, 4'b0011, 40, 1, 0, 0, 1, 30,  4'b0000,  50, 1, 1, 0);
      add(0, 4'b0011, 40, 1, 0, 0, 0, 0,   4'b0001,  10, 1, 0, 0);
      for (int d = 1; d <= 8; d++)
         add(0, 4'b0110, 0, 40, 1, 0, 0, 0, 4'b0100, 10 - d, 1, (d == 8), 0);
      // reset while in RESERVE with requests held: grant void, state back to reset values
      add(1, 4'b0110, 0, 40, 1, 0, 0, 0,   4'b0000, 256, 1, 0, 0);
      add(0, 4'hF,    1, 1, 1, 1, 0, 0,    4'b0001, 255, 1, 0, 0);
      add(0, 4'h0,    0, 0, 0, 0, 1, 245,  4'b0000, 500, 1, 0, 0);
      add(0, 4'h0,    0, 0, 0, 0, 1, 12,   4'b0000, 512, 1, 0, 0);
      add(0, 4'b0010, 0,12, 0, 0, 0, 0,    4'b0010, 500, 1, 0, 0);
      add(0, 4'h0,    0, 0, 0, 0, 1, 20,   4'b0000, 512, 1, 0, 1);
      add(0, 4'b0100, 0, 0, 5, 0, 0, 0,    4'b0100, 507, 1, 0, 1);

      RST      = 1'b1;
      req__ENA = 4'hF;
      req__v   = {6'd1, 6'd1, 6'd1, 6'd1};
      ret__ENA = 1'b0;
      ret__v   = '0;
      @(negedge CLK);
      #1;
      n_vec++;
      chk("rdy_in_reset", -1, 32'(req__RDY), 32'd0);
      $display("reset: rdy=%b", req__RDY);
      @(negedge CLK);
      RST      = 1'b0;
      req__ENA = 4'h0;
      #1;
      n_vec++;
      chk("reset_read", -1, 32'(read), 32'd256);
      chk("reset_positive", -1, 32'(positive), 32'd1);
      chk("reset_rdy", -1, 32'(req__RDY), 32'd0);
      chk("reset_reserve", -1, 32'(reserve_active), 32'd0);
      chk("reset_overflow", -1, 32'(overflow_err), 32'd0);
      chk("ret_rdy", -1, 32'(ret__RDY), 32'd1);
      $display("after reset: read=%0d pos=%0b rsv=%0b ovf=%0b", read, positive, reserve_active, overflow_err);

      for (int k = 0; k < n_tbl; k++) begin
         apply(k);
      end

      // idle cycle: sticky overflow must hold, then clear on reset
      @(negedge CLK);
      RST      = 1'b0;
      req__ENA = 4'h0;
      ret__ENA = 1'b0;
      @(posedge CLK);
      #1;
      n_vec++;
      chk("ovf_sticky", -2, 32'(overflow_err), 32'd1);
      chk("idle_read", -2, 32'(read), 32'd507);
      $display("idle: read=%0d ovf=%0b", read, overflow_err);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      n_vec++;
      chk("ovf_cleared", -3, 32'(overflow_err), 32'd0);
      chk("rst_read", -3, 32'(read), 32'd256);
      $display("final reset: read=%0d ovf=%0b", read, overflow_err);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
